// File: rtl/glb_bank_memory_tiled.sv
// Global-buffer bank memory: NUM_MACROS single-port SRAM macros tiled in depth behind one
// bank port, with a configurable read pipeline, hold-last-read output and collision flag.

module glb_bank_sram_gen #(
  parameter int DATA_WIDTH = 64,
  parameter int ADDR_WIDTH = 12
) (
  input  logic                  clk,
  input  logic                  ceb,
  input  logic                  web,
  input  logic [ADDR_WIDTH-1:0] a,
  input  logic [DATA_WIDTH-1:0] d,
  input  logic [DATA_WIDTH-1:0] bweb,
  output logic [DATA_WIDTH-1:0] q
);
  logic [DATA_WIDTH-1:0] mem [2**ADDR_WIDTH];
  logic [DATA_WIDTH-1:0] q_stage;
  logic                  rd_pend;

  // NOTE: the array has no reset branch; SRAM contents survive reset and a reset loop
  // over the whole array would not map onto a macro.
  always_ff @(posedge clk) begin
    if (!ceb) begin
      if (!web) mem[a] <= (mem[a] & bweb) | (d & ~bweb);
      else      q_stage <= mem[a];
    end
    rd_pend <= !ceb && web;
    if (rd_pend) q <= q_stage;
  end
endmodule

module glb_bank_memory_tiled #(
  parameter int DATA_WIDTH   = 64,
  parameter int ADDR_WIDTH   = 17,
  parameter int BYTE_OFFSET  = 3,
  parameter int NUM_MACROS   = 4,
  parameter int READ_LATENCY = 3
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  ren,
  input  logic                  wen,
  input  logic [ADDR_WIDTH-1:0] addr,
  input  logic [DATA_WIDTH-1:0] data_in,
  input  logic [DATA_WIDTH-1:0] data_in_bit_sel,
  output logic [DATA_WIDTH-1:0] data_out,
  output logic                  data_out_valid,
  output logic                  collision
);
  localparam int WORD_W   = ADDR_WIDTH - BYTE_OFFSET;
  localparam int IDX_W    = $clog2(NUM_MACROS);
  localparam int SEL_W    = (IDX_W > 0) ? IDX_W : 1;
  localparam int MACRO_AW = WORD_W - IDX_W;

  logic [WORD_W-1:0]     word_addr;
  logic [MACRO_AW-1:0]   macro_addr;
  logic [SEL_W-1:0]      macro_idx;
  logic [DATA_WIDTH-1:0] macro_q [NUM_MACROS];
  logic [DATA_WIDTH-1:0] mux_q;
  logic                  rd_fire;
  logic [SEL_W-1:0]      sel_r0, sel_r1;
  logic                  rd_v0, rd_v1;
  logic                  pipe_valid;
  logic [DATA_WIDTH-1:0] pipe_data;
  logic [DATA_WIDTH-1:0] hold_q;
  logic                  unused_byte_bits;

  assign word_addr        = addr[ADDR_WIDTH-1:BYTE_OFFSET];
  assign macro_addr       = word_addr[MACRO_AW-1:0];
  assign unused_byte_bits = ^addr[BYTE_OFFSET-1:0];
  // A collision keeps the write and drops the read.
  assign rd_fire          = ren && !wen;

  if (IDX_W == 0) begin : g_one_macro
    assign macro_idx = '0;
    assign mux_q     = macro_q[0];
  end else begin : g_idx
    assign macro_idx = word_addr[WORD_W-1 -: IDX_W];
    assign mux_q     = macro_q[sel_r1];
  end

  for (genvar m = 0; m < NUM_MACROS; m++) begin : g_macro
    glb_bank_sram_gen #(
      .DATA_WIDTH (DATA_WIDTH),
      .ADDR_WIDTH (MACRO_AW)
    ) u_sram (
      .clk  (clk),
      .ceb  (!((ren || wen) && (macro_idx == SEL_W'(m)))),
      .web  (!wen),
      .a    (macro_addr),
      .d    (data_in),
      .bweb (~data_in_bit_sel),
      .q    (macro_q[m])
    );
  end

  // The macro select travels with the read so interleaved reads pick their own macro's Q.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sel_r0    <= '0;
      sel_r1    <= '0;
      rd_v0     <= 1'b0;
      rd_v1     <= 1'b0;
      collision <= 1'b0;
    end else begin
      if (rd_fire) sel_r0 <= macro_idx;
      sel_r1    <= sel_r0;
      rd_v0     <= rd_fire;
      rd_v1     <= rd_v0;
      collision <= ren && wen;
    end
  end

  if (READ_LATENCY == 1) begin : g_lat1
    assign pipe_valid = rd_v1;
    assign pipe_data  = mux_q;
  end else begin : g_latn
    logic [READ_LATENCY-2:0]                 v_pipe;
    logic [READ_LATENCY-2:0][DATA_WIDTH-1:0] d_pipe;
    logic [READ_LATENCY-1:0]                 v_shift;
    logic [READ_LATENCY-1:0][DATA_WIDTH-1:0] d_shift;

    assign v_shift = {v_pipe, rd_v1};
    assign d_shift = {d_pipe, mux_q};

    always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
        v_pipe <= '0;
        d_pipe <= '0;
      end else begin
        v_pipe <= v_shift[READ_LATENCY-2:0];
        d_pipe <= d_shift[READ_LATENCY-2:0];
      end
    end

    assign pipe_valid = v_pipe[READ_LATENCY-2];
    assign pipe_data  = d_pipe[READ_LATENCY-2];
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)        hold_q <= '0;
    else if (pipe_valid) hold_q <= pipe_data;
  end

  assign data_out_valid = pipe_valid;
  assign data_out       = pipe_valid ? pipe_data : hold_q;
endmodule

// File: tb/tb_glb_bank_memory_tiled.sv
// Scoreboard bench: three bank instances (default, latency 1 / one macro, latency 4 / 16 macros)
// share one stimulus stream; a negedge monitor checks data and arrival cycle per instance.

module tb_glb_bank_memory_tiled;
  localparam int DW   = 64;
  localparam int AW   = 17;
  localparam int NDUT = 3;
  localparam int LAT [NDUT] = '{3, 1, 4};

  typedef struct {
    logic [DW-1:0] data;
    int unsigned   edge_n;
  } exp_t;

  logic          clk = 1'b0;
  logic          reset_n = 1'b0;
  logic          ren = 1'b0;
  logic          wen = 1'b0;
  logic [AW-1:0] addr = '0;
  logic [DW-1:0] data_in = '0;
  logic [DW-1:0] bit_sel = '0;
  logic [DW-1:0] dout [NDUT];
  logic          dv   [NDUT];
  logic          col  [NDUT];

  exp_t        sb [NDUT][$];
  int unsigned cyc = 0;
  int          checks = 0;
  int          errors = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  glb_bank_memory_tiled u_dut (
    .clk(clk), .reset_n(reset_n), .ren(ren), .wen(wen), .addr(addr),
    .data_in(data_in), .data_in_bit_sel(bit_sel),
    .data_out(dout[0]), .data_out_valid(dv[0]), .collision(col[0]));

  glb_bank_memory_tiled #(.NUM_MACROS(1), .READ_LATENCY(1)) u_dut_l1 (
    .clk(clk), .reset_n(reset_n), .ren(ren), .wen(wen), .addr(addr),
    .data_in(data_in), .data_in_bit_sel(bit_sel),
    .data_out(dout[1]), .data_out_valid(dv[1]), .collision(col[1]));

  glb_bank_memory_tiled #(.NUM_MACROS(16), .READ_LATENCY(4)) u_dut_l4 (
    .clk(clk), .reset_n(reset_n), .ren(ren), .wen(wen), .addr(addr),
    .data_in(data_in), .data_in_bit_sel(bit_sel),
    .data_out(dout[2]), .data_out_valid(dv[2]), .collision(col[2]));

  task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: actual %h required %h", name, act, exp);
    end
  endtask

  // Monitor: every valid must match the oldest outstanding read, on its exact cycle.
  always @(negedge clk) begin
    if (reset_n) begin
      for (int k = 0; k < NDUT; k++) begin
        if (dv[k]) begin
          if (sb[k].size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_valid dut%0d: actual valid=1 (data %h) required valid=0", k, dout[k]);
          end else begin
            exp_t e;
            e = sb[k].pop_front();
            check($sformatf("rd_data_dut%0d", k), dout[k], e.data);
            check($sformatf("rd_cycle_dut%0d", k), DW'(cyc), DW'(e.edge_n + LAT[k]));
          end
        end
      end
    end
  end

  task automatic op(input logic r, input logic w, input logic [AW-1:0] a,
                    input logic [DW-1:0] d, input logic [DW-1:0] s);
    @(negedge clk);
    ren = r; wen = w; addr = a; data_in = d; bit_sel = s;
  endtask

  task automatic wr(input logic [AW-1:0] a, input logic [DW-1:0] d, input logic [DW-1:0] s);
    op(1'b0, 1'b1, a, d, s);
  endtask

  task automatic rd(input logic [AW-1:0] a, input logic [DW-1:0] exp);
    op(1'b1, 1'b0, a, '0, '0);
    for (int k = 0; k < NDUT; k++) sb[k].push_back('{exp, cyc + 1});
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clk);
      ren = 1'b0; wen = 1'b0;
    end
  endtask

  task automatic check_all(input string name, input logic [DW-1:0] exp_d,
                           input logic exp_v, input logic exp_c);
    for (int k = 0; k < NDUT; k++) begin
      check($sformatf("%s_data_dut%0d", name, k), dout[k], exp_d);
      check($sformatf("%s_valid_dut%0d", name, k), DW'(dv[k]), DW'(exp_v));
      check($sformatf("%s_coll_dut%0d", name, k), DW'(col[k]), DW'(exp_c));
    end
  endtask

  initial begin
    repeat (3) @(negedge clk);
    #1 check_all("reset", '0, 1'b0, 1'b0);
    @(negedge clk);
    reset_n = 1'b1;

    // Basic read, then the value must hold once valid drops.
    wr(17'h00008, 64'hDEADBEEF_CAFEF00D, '1);
    rd(17'h00008, 64'hDEADBEEF_CAFEF00D);
    idle(7);
    #1 check_all("hold", 64'hDEADBEEF_CAFEF00D, 1'b0, 1'b0);

    // Word 0 of each default macro (word addresses 0x0000/0x1000/0x2000/0x3000).
    wr(17'h00000, 64'h1111_0000_0000_0001, '1);
    wr(17'h08000, 64'h2222_0000_0000_0002, '1);
    wr(17'h10000, 64'h3333_0000_0000_0003, '1);
    wr(17'h18000, 64'h4444_0000_0000_0004, '1);
    rd(17'h00000, 64'h1111_0000_0000_0001);
    rd(17'h08000, 64'h2222_0000_0000_0002);
    rd(17'h10000, 64'h3333_0000_0000_0003);
    rd(17'h18000, 64'h4444_0000_0000_0004);
    idle(8);

    // Bit-select: only the low half is rewritten.
    wr(17'h00020, '1, '1);
    wr(17'h00020, '0, 64'h00000000_FFFFFFFF);
    rd(17'h00020, 64'hFFFFFFFF_00000000);
    idle(6);

    // Collision: write lands, read is dropped, flag pulses for one cycle.
    op(1'b1, 1'b1, 17'h00010, 64'h55, '1);
    @(negedge clk);
    ren = 1'b0; wen = 1'b0;
    #1 for (int k = 0; k < NDUT; k++) check($sformatf("coll_pulse_dut%0d", k), DW'(col[k]), DW'(1));
    @(negedge clk);
    #1 for (int k = 0; k < NDUT; k++) check($sformatf("coll_clear_dut%0d", k), DW'(col[k]), DW'(0));
    rd(17'h00010, 64'h55);
    idle(6);

    // Read directly after a partial write to the same word.
    wr(17'h00018, 64'h01234567_89ABCDEF, '1);
    wr(17'h00018, '1, 64'hFFFF0000_00000000);
    rd(17'h00018, 64'hFFFF4567_89ABCDEF);
    idle(6);

    // Reset one cycle after a read: the read disappears, memory survives.
    op(1'b1, 1'b0, 17'h00008, '0, '0);
    @(negedge clk);
    ren = 1'b0;
    #2 reset_n = 1'b0;
    for (int k = 0; k < NDUT; k++) sb[k].delete();
    #1 check_all("midreset", '0, 1'b0, 1'b0);
    repeat (2) @(negedge clk);
    #1 reset_n = 1'b1;
    idle(5);
    rd(17'h00008, 64'hDEADBEEF_CAFEF00D);
    rd(17'h00000, 64'h1111_0000_0000_0001);
    idle(8);

    for (int i = 0; i < 30; i++) begin
      if (sb[0].size() == 0 && sb[1].size() == 0 && sb[2].size() == 0) break;
      @(negedge clk);
    end
    for (int k = 0; k < NDUT; k++) check($sformatf("drain_dut%0d", k), DW'(sb[k].size()), '0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/glb_bank_memory_tiled.md
Name: glb_bank_memory_tiled

Overview:
- Next-generation global-buffer bank memory.
- Tiles NUM_MACROS single-port SRAM macros (glb_bank_sram_gen) in depth behind one bank port.
- Provides a configurable read pipeline, an explicit read-valid output, hold-last-read output data and read/write collision reporting.
- Sits between the bank controller and the SRAM macros, one instance per GLB bank.

Parameters:
- DATA_WIDTH, 64, bank word width in bits.
- ADDR_WIDTH, 17, bank byte-address width.
- BYTE_OFFSET, 3, low address bits ignored (log2 of bytes per word).
- NUM_MACROS, 4, SRAM macros tiled in depth; power of two, 1..16.
- READ_LATENCY, 3, cycles from the ren sample edge to data_out_valid; legal range 1..4.

Ports:
- clk  in  1  bank clock.
- reset_n  in  1  asynchronous, active-low reset.
- ren  in  1  read request, sampled at posedge clk.
- wen  in  1  write request, sampled at posedge clk.
- addr  in  ADDR_WIDTH  byte address.
- data_in  in  DATA_WIDTH  write data.
- data_in_bit_sel  in  DATA_WIDTH  per-bit write enable; 1 means write the bit.
- data_out  out  DATA_WIDTH  read data; holds the last delivered value when not valid.
- data_out_valid  out  1  data_out carries the result of a read this cycle.
- collision  out  1  registered pulse: ren and wen were both high last cycle.

Behaviour:
- Clock/reset: one clock, clk. reset_n is asynchronous, active-low.
- Address decode:
  - word address = addr[ADDR_WIDTH-1:BYTE_OFFSET].
  - macro index = upper log2(NUM_MACROS) bits of the word address.
  - macro address = remaining lower bits.
  - With NUM_MACROS=1 there is no index field.
- Macro enable: only the selected macro gets CEB low; all other macros stay idle (CEB high).
- Macro drive:
  - WEB = ~wen on the selected macro.
  - BWEB = ~data_in_bit_sel.
  - D = data_in, broadcast to all macros.
- Collision (ren and wen both high in one cycle):
  - The write proceeds; the read is dropped (no valid is issued for it).
  - collision = 1 for exactly the next cycle.
- Read pipeline:
  - A read sampled at edge t records its macro index in a select register.
  - Macro Q is valid after edge t+1. The Q of the recorded macro is muxed into a valid/data shift pipeline with READ_LATENCY-1 register stages.
  - data_out_valid = 1 in the cycle following edge t+READ_LATENCY.
  - READ_LATENCY=1: data_out is the combinational mux of macro Q, gated by the 1-cycle valid.
- Throughput: back-to-back reads are accepted every cycle and returned in order, one per cycle, with no bubbles.
- Hold: a hold register captures data_out whenever data_out_valid = 1. While data_out_valid = 0, data_out drives the hold register.
- Read-after-write: a write at edge t and a read of the same address at edge t+1 returns the new data, filtered by bit_sel.
- Macro interleaving: a read to macro A followed by a read to macro B returns each result from its own macro. The select is pipelined with the data, not taken from the current address.
- Reset (asserted at any time, including mid-read):
  - data_out = 0, data_out_valid = 0, collision = 0, hold register = 0.
  - All in-flight reads are discarded.
  - SRAM contents are not cleared.
  - The first read after reset_n deasserts behaves normally.
- Width rules: all data paths are DATA_WIDTH. Macro depth = 2^(ADDR_WIDTH-BYTE_OFFSET) / NUM_MACROS words.

Test Plan:
- Basic read:
  - Stimulus: defaults; write 0xDEADBEEF_CAFEF00D to addr 0x0008 with bit_sel all-ones; read addr 0x0008.
  - Required: data_out_valid high exactly 3 cycles after the read edge, data_out = 0xDEADBEEF_CAFEF00D; value held after valid drops.
- Macro interleave:
  - Stimulus: write distinct words to word 0 of each of the 4 macros (word addresses 0x0000, 0x1000, 0x2000, 0x3000); read all four back-to-back.
  - Required: 4 consecutive valid cycles, data in request order.
- Bit-select:
  - Stimulus: preload all-ones; write 0x0 with bit_sel=0x00000000_FFFFFFFF; read.
  - Required: 0xFFFFFFFF_00000000.
- Collision:
  - Stimulus: ren=wen=1 on addr 0x10 with data 0x55.
  - Required: collision=1 for one cycle, no data_out_valid for that request; a later read returns 0x55.
- Reset mid-read:
  - Stimulus: issue a read, assert reset_n low one cycle later.
  - Required: data_out=0, valid never asserts for that read; memory contents are preserved and readable after reset.
- Latency sweep:
  - Stimulus: READ_LATENCY=1 and 4, NUM_MACROS=1 and 16.
  - Required: valid appears at exactly READ_LATENCY cycles with correct data.
